// File: rtl/mips_pkg.sv
// Shared types and constants for the data-memory path.
// States, requester ids and the data-memory depth.
package mips_pkg;

  localparam int DMEM_DEPTH = 100;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } dmem_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; remembers the last winner.
// i_req[0]=cpu, i_req[1]=dbg; o_gnt one-hot; i_accept commits.
module rr_arb2
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  owner_t r_last;

  // Under contention the requester that did not win last goes.
  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b11: o_gnt = (r_last == OWN_DBG) ? 2'b01 : 2'b10;
      2'b01: o_gnt = 2'b01;
      2'b10: o_gnt = 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Reset to dbg so the cpu wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= OWN_DBG;
    end else if (i_accept && (|o_gnt)) begin
      r_last <= o_gnt[1] ? OWN_DBG : OWN_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between cpu and dbg requesters.
// Ports: cpu_*/dbg_* req/ack pairs, mem_* memory side, busy, owner.
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int ADDR_W  = 7,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int          CNT_W   = 3;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  dmem_state_t r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic r_we, w_we_n;
  owner_t r_owner, w_owner_n;

  logic              r_mem_en, w_mem_en_n;
  logic              r_mem_we, w_mem_we_n;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_n;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_n;
  logic              r_cpu_ack, w_cpu_ack_n;
  logic              r_dbg_ack, w_dbg_ack_n;
  logic [DATA_W-1:0] r_cpu_rdata, r_dbg_rdata;
  logic              r_cpu_err, r_dbg_err;
  logic [DATA_W-1:0] w_rdata_n;
  logic              w_err_n;
  logic              r_busy;

  logic [1:0]        w_gnt;
  logic              w_accept;
  logic              w_sel_we;
  logic [31:0]       w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_in_rng;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (reset),
    .i_req    ({dbg_req, cpu_req}),
    .i_accept (w_accept),
    .o_gnt    (w_gnt)
  );

  always_comb begin
    w_sel_we    = w_gnt[1] ? dbg_we    : cpu_we;
    w_sel_addr  = w_gnt[1] ? dbg_addr  : cpu_addr;
    w_sel_wdata = w_gnt[1] ? dbg_wdata : cpu_wdata;
    // Unsigned 32-bit compare also rejects negative sums.
    w_in_rng    = (w_sel_addr < DEPTH_U);
  end

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_we_n        = r_we;
    w_owner_n     = r_owner;
    w_accept      = 1'b0;
    w_mem_en_n    = 1'b0;
    w_mem_we_n    = 1'b0;
    w_mem_addr_n  = '0;
    w_mem_wdata_n = '0;
    w_cpu_ack_n   = 1'b0;
    w_dbg_ack_n   = 1'b0;
    w_rdata_n     = '0;
    w_err_n       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|w_gnt) begin
          w_accept  = 1'b1;
          w_we_n    = w_sel_we;
          w_owner_n = w_gnt[1] ? OWN_DBG : OWN_CPU;
          if (w_in_rng) begin
            w_state_n     = ISSUE;
            w_mem_en_n    = 1'b1;
            w_mem_we_n    = w_sel_we;
            w_mem_addr_n  = w_sel_addr[ADDR_W-1:0];
            w_mem_wdata_n = w_sel_wdata;
          end else begin
            w_state_n   = RESP;
            w_err_n     = 1'b1;
            w_cpu_ack_n = w_gnt[0];
            w_dbg_ack_n = w_gnt[1];
          end
        end
      end
      ISSUE: begin
        w_state_n = WAIT;
        w_cnt_n   = CNT_W'(MEM_LAT);
      end
      WAIT: begin
        w_cnt_n = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_n   = RESP;
          w_cpu_ack_n = (r_owner == OWN_CPU);
          w_dbg_ack_n = (r_owner == OWN_DBG);
          w_rdata_n   = r_we ? '0 : mem_rdata;
        end
      end
      RESP: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_owner     <= OWN_CPU;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
      r_cpu_err   <= 1'b0;
      r_dbg_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_we        <= w_we_n;
      r_owner     <= w_owner_n;
      r_mem_en    <= w_mem_en_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_cpu_ack   <= w_cpu_ack_n;
      r_dbg_ack   <= w_dbg_ack_n;
      r_cpu_rdata <= w_cpu_ack_n ? w_rdata_n : '0;
      r_dbg_rdata <= w_dbg_ack_n ? w_rdata_n : '0;
      r_cpu_err   <= w_cpu_ack_n & w_err_n;
      r_dbg_err   <= w_dbg_ack_n & w_err_n;
      r_busy      <= (w_state_n != IDLE);
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign cpu_err   = r_cpu_err;
  assign dbg_ack   = r_dbg_ack;
  assign dbg_rdata = r_dbg_rdata;
  assign dbg_err   = r_dbg_err;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign owner     = r_owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter at MEM_LAT=1 and MEM_LAT=3.
// Memory models sit beside each instance.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic        c_ack, c_err, d_ack, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        m_en, m_we, busy, owner;
  logic [6:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  logic        d3_req;
  logic [31:0] d3_addr;
  logic        c3_ack, c3_err, d3_ack, d3_err;
  logic [31:0] c3_rdata, d3_rdata;
  logic        m3_en, m3_we, busy3, owner3;
  logic [6:0]  m3_addr;
  logic [31:0] m3_wdata, m3_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(rst_n),
    .cpu_req(c_req), .cpu_we(c_we),
    .cpu_addr(c_addr), .cpu_wdata(c_wdata),
    .cpu_ack(c_ack), .cpu_rdata(c_rdata),
    .cpu_err(c_err),
    .dbg_req(d_req), .dbg_we(d_we),
    .dbg_addr(d_addr), .dbg_wdata(d_wdata),
    .dbg_ack(d_ack), .dbg_rdata(d_rdata),
    .dbg_err(d_err),
    .mem_en(m_en), .mem_we(m_we),
    .mem_addr(m_addr), .mem_wdata(m_wdata),
    .mem_rdata(m_rdata),
    .busy(busy), .owner(owner)
  );

  dmem_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(rst_n),
    .cpu_req(1'b0), .cpu_we(1'b0),
    .cpu_addr(32'd0), .cpu_wdata(32'd0),
    .cpu_ack(c3_ack), .cpu_rdata(c3_rdata),
    .cpu_err(c3_err),
    .dbg_req(d3_req), .dbg_we(1'b0),
    .dbg_addr(d3_addr), .dbg_wdata(32'd0),
    .dbg_ack(d3_ack), .dbg_rdata(d3_rdata),
    .dbg_err(d3_err),
    .mem_en(m3_en), .mem_we(m3_we),
    .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_rdata(m3_rdata),
    .busy(busy3), .owner(owner3)
  );

  // Latency-1 memory; unwritten words read 0x1000_0000+index.
  bit [31:0] mem [128];
  bit        wv  [128];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) begin
        mem[m_addr] <= m_wdata;
        wv[m_addr]  <= 1'b1;
      end
      m_rdata <= wv[m_addr] ? mem[m_addr]
                            : 32'h1000_0000 + 32'(m_addr);
    end
  end

  // Latency-3 memory; data is 0 except on the valid cycle.
  logic [31:0] s0, s1, s2;
  always @(posedge clk) begin
    s0 <= m3_en ? 32'hDEAD_BEEF : 32'd0;
    s1 <= s0;
    s2 <= s1;
  end
  assign m3_rdata = s2;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input string tag,
                         input logic sel,
                         input logic we,
                         input logic [31:0] addr,
                         input logic [31:0] wd,
                         input int exp_lat,
                         input logic [31:0] exp_rd,
                         input logic exp_err);
    int n, men, other;
    logic got, er, mwe;
    logic [31:0] rd, ma, mwd;
    n = 0; men = 0; other = 0;
    got = 0; er = 0; rd = 0;
    mwe = 0; ma = 0; mwd = 0;
    if (sel) begin
      d_req = 1; d_we = we;
      d_addr = addr; d_wdata = wd;
    end else begin
      c_req = 1; c_we = we;
      c_addr = addr; c_wdata = wd;
    end
    while (!got && n < 20) begin
      tick;
      n++;
      if (m_en) begin
        men++;
        mwe = m_we;
        ma = 32'(m_addr);
        mwd = m_wdata;
      end
      if (sel ? c_ack : d_ack) other++;
      if (sel ? d_ack : c_ack) begin
        got = 1;
        rd = sel ? d_rdata : c_rdata;
        er = sel ? d_err : c_err;
      end
    end
    c_req = 0;
    d_req = 0;
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
    chk({tag, "_men"}, men, exp_err ? 0 : 1);
    chk({tag, "_other"}, other, 0);
    if (!exp_err) begin
      chk({tag, "_maddr"}, ma, addr);
      chk({tag, "_mwe"}, 32'(mwe), 32'(we));
      if (we) chk({tag, "_mwd"}, mwd, wd);
    end
    tick;
    chk({tag, "_idle"},
        {28'd0, c_ack, d_ack, busy, m_en}, 32'd0);
  endtask

  task automatic contend(input string tag);
    int who[$];
    logic [31:0] ma[$];
    logic [31:0] crd, drd;
    int both;
    crd = 0; drd = 0; both = 0;
    c_req = 1; c_we = 0; c_addr = 3;
    d_req = 1; d_we = 0; d_addr = 7;
    for (int i = 0; i < 14; i++) begin
      tick;
      if (m_en) ma.push_back(32'(m_addr));
      if (c_ack && d_ack) both++;
      if (c_ack) begin
        who.push_back(0);
        if (crd == 0) crd = c_rdata;
      end
      if (d_ack) begin
        who.push_back(1);
        if (drd == 0) drd = d_rdata;
      end
    end
    c_req = 0;
    d_req = 0;
    repeat (4) tick;
    chk({tag, "_nack"}, who.size(), 3);
    chk({tag, "_nmen"}, ma.size(), 4);
    while (who.size() < 3) who.push_back(9);
    while (ma.size() < 3) ma.push_back(32'hFF);
    chk({tag, "_g0"}, who[0], 0);
    chk({tag, "_g1"}, who[1], 1);
    chk({tag, "_g2"}, who[2], 0);
    chk({tag, "_a0"}, ma[0], 3);
    chk({tag, "_a1"}, ma[1], 7);
    chk({tag, "_a2"}, ma[2], 3);
    chk({tag, "_crd"}, crd, 32'h1000_0003);
    chk({tag, "_drd"}, drd, 32'h1000_0007);
    chk({tag, "_both"}, both, 0);
  endtask

  initial begin
    int n, lo, men, acks, dacks;
    int idx[$];
    logic [31:0] rd;
    rst_n = 0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    d3_req = 0; d3_addr = 0;
    repeat (3) tick;
    chk("rst_ctl",
        {25'd0, c_ack, d_ack, c_err, d_err,
         m_en, busy, owner}, 32'd0);
    chk("rst_cdata", c_rdata, 32'd0);
    chk("rst_maddr", 32'(m_addr), 32'd0);
    chk("rst_ctl3",
        {28'd0, d3_ack, m3_en, busy3, owner3}, 32'd0);
    rst_n = 1;
    tick;

    run_txn("wr5", 0, 1, 5, 32'h0000_00AB, 3, 0, 0);
    run_txn("rd5", 0, 0, 5, 0, 3, 32'h0000_00AB, 0);
    run_txn("dwr99", 1, 1, 99, 32'h5A5A_0099, 3, 0, 0);
    run_txn("drd99", 1, 0, 99, 0, 3, 32'h5A5A_0099, 0);
    run_txn("rd0", 0, 0, 0, 0, 3, 32'h1000_0000, 0);
    run_txn("oor100", 0, 0, 100, 0, 1, 0, 1);
    run_txn("oorneg", 0, 1, 32'hFFFF_FFFF,
            32'h1234, 1, 0, 1);
    run_txn("door", 1, 0, 32'h0000_0080, 0, 1, 0, 1);

    rst_n = 0;
    tick;
    rst_n = 1;
    tick;
    contend("cont0");

    d3_req = 1;
    d3_addr = 99;
    n = 0; lo = 0; men = 0; rd = 0;
    while (n < 20 && !d3_ack) begin
      tick;
      n++;
      if (!busy3) lo++;
      if (m3_en) men++;
    end
    rd = d3_rdata;
    chk("l3_lat", n, 5);
    chk("l3_rdata", rd, 32'hDEAD_BEEF);
    chk("l3_err", 32'(d3_err), 0);
    chk("l3_busylo", lo, 0);
    chk("l3_men", men, 1);
    chk("l3_cack", 32'(c3_ack), 0);
    d3_req = 0;
    tick;
    chk("l3_idle", {30'd0, d3_ack, busy3}, 0);

    c_req = 1; c_we = 0; c_addr = 5;
    tick;
    chk("rw_issue", 32'(m_en), 1);
    tick;
    chk("rw_busy", 32'(busy), 1);
    rst_n = 0;
    #1;
    chk("rw_async",
        {28'd0, m_en, busy, c_ack, d_ack}, 0);
    c_req = 0;
    tick;
    rst_n = 1;
    tick;
    c_req = 1;
    tick;
    chk("ri_issue", 32'(m_en), 1);
    rst_n = 0;
    #1;
    chk("ri_async", {30'd0, m_en, busy}, 0);
    c_req = 0;
    #1;
    rst_n = 1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (c_ack || d_ack || m_en) acks++;
    end
    chk("rst_quiet", acks, 0);
    contend("cont_rst");

    c_req = 1; c_we = 0; c_addr = 3;
    dacks = 0; men = 0;
    for (int i = 1; i <= 8; i++) begin
      tick;
      if (c_ack) idx.push_back(i);
      if (d_ack) dacks++;
      if (m_en) men++;
    end
    c_req = 0;
    chk("hold_nack", idx.size(), 2);
    while (idx.size() < 2) idx.push_back(0);
    chk("hold_t0", idx[0], 3);
    chk("hold_t1", idx[1], 7);
    chk("hold_dack", dacks, 0);
    chk("hold_men", men, 2);
    tick;
    chk("hold_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 100-word data memory between two requesters: the processor load/store path (cpu) and the debug/loader port (dbg).
- Sequences every access through a small FSM with round-robin arbitration, word-index bounds checking and one-pulse acknowledge.
- Sits between the processor's lw/sw execution stage and the data-memory array. The processor stalls on cpu_req until it sees cpu_ack.

Parameters:
DATA_W, 32, data word width
DEPTH, 100, number of data-memory words; valid word indices are 0..DEPTH-1
ADDR_W, 7, memory-side index width; must satisfy 2**ADDR_W >= DEPTH
MEM_LAT, 1, read latency of the memory in cycles after the mem_en cycle (1..4)

Ports:
clk  in  1  system clock, all logic on the rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
cpu_req  in  1  cpu access request; held with cpu_we/addr/wdata stable until cpu_ack
cpu_we  in  1  1 = store (sw), 0 = load (lw)
cpu_addr  in  32  word index, computed as rs + sign-extended immediate
cpu_wdata  in  DATA_W  store data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  load data, valid while cpu_ack=1
cpu_err  out  1  out-of-range access, valid while cpu_ack=1
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata, dbg_err  same directions, widths and meanings as the cpu_* ports, for the debug requester
mem_en  out  1  memory access strobe, exactly one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory word index
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
busy  out  1  1 while any state other than IDLE
owner  out  1  current or last granted requester: 0 = cpu, 1 = dbg

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; last_owner=dbg, so cpu wins the first conflict.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one req: grant that requester.
- IDLE, both req: grant the requester that is not last_owner, then set last_owner to the winner. This gives strict alternation under continuous contention.
- On grant: latch we/addr/wdata and set owner.
  - addr >= DEPTH (full 32-bit compare, including huge or negative sums): skip memory, go to RESP with err=1, rdata=0.
  - Otherwise: go to ISSUE.
- ISSUE (1 cycle): mem_en=1; mem_we=latched we; mem_addr=addr[ADDR_W-1:0]; mem_wdata=latched wdata. Next state WAIT, with the latency counter loaded to MEM_LAT.
- WAIT: decrement the counter. At 0, capture mem_rdata (for writes, capture 0) and go to RESP.
- RESP (1 cycle): the granted requester's ack=1, with rdata/err driven. The other requester's ack stays 0. Next state IDLE.
- Latency:
  - In-range access: req sampled at edge N; mem_en high in cycle N+1; ack in cycle N+2+MEM_LAT.
  - Out-of-range access: ack in cycle N+1.
- Handshake rules:
  - The requester must deassert req at the edge that ends its ack cycle. A req still high in IDLE is treated as a new transaction.
  - The losing requester keeps req asserted and is served next.
  - Changing addr/we/wdata while req=1 before ack is illegal. The arbiter ignores it because those fields are latched at grant.
- ack, rdata and err return to 0 in every cycle other than RESP.
- Reset mid-operation: the transaction is abandoned immediately and mem_en drops asynchronously. A write whose mem_en cycle already completed remains in memory. No ack is produced after reset deasserts.
- Requests are only sampled in IDLE. A req arriving during a transaction is held until the next IDLE cycle, so there is one idle cycle between back-to-back transactions.

Decomposition:
- Shared package mips_pkg:
  - enum dmem_state_t {IDLE, ISSUE, WAIT, RESP}
  - enum owner_t {OWN_CPU=0, OWN_DBG=1}
  - constant DMEM_DEPTH=100
- One sub-module, rr_arb2: two-input round-robin arbiter holding last_owner. Inputs: req[1:0] and a grant-accept strobe. Output: one-hot gnt. Everything else stays in dmem_arbiter.

Test Plan:
- MEM_LAT=1, cpu write addr=5, wdata=32'h0000_00AB -> mem_en one cycle with mem_we=1, mem_addr=5; cpu_ack at N+3; then cpu read addr=5 returns cpu_rdata=32'h0000_00AB, cpu_err=0.
- cpu and dbg both request from reset (cpu read 3, dbg read 7) -> cpu served first (mem_addr=3), then dbg (mem_addr=7); both held continuously -> grants alternate cpu, dbg, cpu.
- cpu_addr=100 and cpu_addr=32'hFFFF_FFFF -> no mem_en; cpu_ack at N+1 with cpu_err=1, cpu_rdata=0.
- MEM_LAT=3, dbg read addr=99 with memory returning 32'hDEAD_BEEF -> dbg_ack exactly 5 cycles after the sampling edge, dbg_rdata=32'hDEAD_BEEF, busy high for the whole interval.
- reset driven 0 during WAIT of a cpu read -> mem_en, busy, cpu_ack immediately 0; after reset=1 with no req, no ack appears for 10 cycles; the next conflict grants cpu first.
- cpu_req held high through ack -> a second identical transaction starts on the following IDLE cycle; dbg_ack stays 0 throughout.
